lstm_sequence_scheduler: RTL and testbench

Sequencer in front of the multi-layer LSTM datapath. Accepts a stream of input samples grouped into sequences, clears the per-layer hidden and cell state at each sequence start, and issues one sample to the datapath at a time, only when the datapath is ready. Captures each y/C result into a small output FIFO with backpressure. Sits between the AXI4-Lite register front end (or a DMA stream) and the LSTM layers.

---
 rtl/lstm_sequence_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_lstm_sequence_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_sequence_scheduler.sv
// Sequencer in front of the multi-layer LSTM datapath: clears layer state at
// sequence start, issues one sample at a time and buffers y/C results in a FIFO.
module lstm_sequence_scheduler #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned LAYERS    = 4,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        s_data,
  input  logic                    s_first,
  input  logic                    s_last,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    lstm_ready,
  output logic [WIDTH-1:0]        lstm_x_in,
  output logic                    lstm_x_in_valid,
  output logic [LAYERS*WIDTH-1:0] lstm_c_in,
  output logic [LAYERS*WIDTH-1:0] lstm_h_in,
  output logic [LAYERS-1:0]       lstm_c_in_valid,
  output logic [LAYERS-1:0]       lstm_h_in_valid,
  input  logic [WIDTH-1:0]        lstm_y_out,
  input  logic [WIDTH-1:0]        lstm_c_out,
  input  logic                    lstm_valid,
  output logic [WIDTH-1:0]        m_y,
  output logic [WIDTH-1:0]        m_c,
  output logic                    m_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [15:0]             seq_count,
  output logic                    seq_err,
  output logic                    timeout_err,
  output logic                    busy
);

  localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, WAIT} state_t;

  state_t            state;
  logic              cleared;
  logic              last_q;
  logic [TW-1:0]     wait_cnt;

  logic [WIDTH-1:0]  y_mem    [OUT_DEPTH];
  logic [WIDTH-1:0]  c_mem    [OUT_DEPTH];
  logic              last_mem [OUT_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_count;

  logic              fifo_space_c;
  logic              first_block_c;
  logic              take_c;
  logic              push_c;
  logic              pop_c;

  // A sequence-start sample must pass through CLEAR before it may be issued.
  assign fifo_space_c  = (fifo_count < CW'(OUT_DEPTH));
  assign first_block_c = s_first && !cleared;
  assign s_ready       = (state == ISSUE) && lstm_ready && fifo_space_c && !first_block_c;
  assign take_c        = s_valid && s_ready;
  assign push_c        = (state == WAIT) && lstm_valid;
  assign m_valid       = (fifo_count != '0);
  assign pop_c         = m_valid && m_ready;

  assign m_y       = m_valid ? y_mem[rd_ptr]    : '0;
  assign m_c       = m_valid ? c_mem[rd_ptr]    : '0;
  assign m_last    = m_valid ? last_mem[rd_ptr] : 1'b0;
  assign lstm_c_in = '0;
  assign lstm_h_in = '0;

  // Sequencer FSM with registered datapath strobes and status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      cleared         <= 1'b0;
      last_q          <= 1'b0;
      wait_cnt        <= '0;
      lstm_x_in       <= '0;
      lstm_x_in_valid <= 1'b0;
      lstm_c_in_valid <= '0;
      lstm_h_in_valid <= '0;
      seq_count       <= '0;
      seq_err         <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      lstm_x_in_valid <= 1'b0;
      lstm_c_in_valid <= '0;
      lstm_h_in_valid <= '0;
      unique case (state)
        IDLE: begin
          if (s_valid) begin
            busy <= 1'b1;
            if (s_first) begin
              state           <= CLEAR;
              lstm_c_in_valid <= '1;
              lstm_h_in_valid <= '1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        CLEAR: begin
          seq_count <= '0;
          cleared   <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (s_valid && first_block_c) begin
            seq_err         <= 1'b1;
            state           <= CLEAR;
            lstm_c_in_valid <= '1;
            lstm_h_in_valid <= '1;
          end else if (take_c) begin
            lstm_x_in       <= s_data;
            lstm_x_in_valid <= 1'b1;
            last_q          <= s_last;
            cleared         <= 1'b0;
            wait_cnt        <= '0;
            state           <= WAIT;
            if (seq_count != 16'hFFFF) begin
              seq_count <= seq_count + 16'd1;
            end
          end
        end
        WAIT: begin
          if (lstm_valid) begin
            if (last_q) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ISSUE;
            end
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Result storage; contents need no reset since the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push_c) begin
      y_mem[wr_ptr]    <= lstm_y_out;
      c_mem[wr_ptr]    <= lstm_c_out;
      last_mem[wr_ptr] <= last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_c && !pop_c) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (!push_c && pop_c) begin
        fifo_count <= fifo_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_lstm_sequence_scheduler.sv
// Scoreboard bench for lstm_sequence_scheduler with a fixed-latency datapath model.
module tb_lstm_sequence_scheduler;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned LAYERS    = 4;
  localparam int unsigned OUT_DEPTH = 4;
  localparam int unsigned TIMEOUT   = 16;
  localparam int          LAT       = 5;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [WIDTH-1:0]        s_data;
  logic                    s_first, s_last, s_valid, s_ready;
  logic                    lstm_ready;
  logic [WIDTH-1:0]        lstm_x_in;
  logic                    lstm_x_in_valid;
  logic [LAYERS*WIDTH-1:0] lstm_c_in, lstm_h_in;
  logic [LAYERS-1:0]       lstm_c_in_valid, lstm_h_in_valid;
  logic [WIDTH-1:0]        lstm_y_out, lstm_c_out;
  logic                    lstm_valid;
  logic [WIDTH-1:0]        m_y, m_c;
  logic                    m_last, m_valid, m_ready;
  logic [15:0]             seq_count;
  logic                    seq_err, timeout_err, busy;

  always #5 clk = ~clk;

  lstm_sequence_scheduler #(
    .WIDTH(WIDTH), .LAYERS(LAYERS), .OUT_DEPTH(OUT_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_first(s_first), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .lstm_ready(lstm_ready), .lstm_x_in(lstm_x_in), .lstm_x_in_valid(lstm_x_in_valid),
    .lstm_c_in(lstm_c_in), .lstm_h_in(lstm_h_in),
    .lstm_c_in_valid(lstm_c_in_valid), .lstm_h_in_valid(lstm_h_in_valid),
    .lstm_y_out(lstm_y_out), .lstm_c_out(lstm_c_out), .lstm_valid(lstm_valid),
    .m_y(m_y), .m_c(m_c), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .seq_count(seq_count), .seq_err(seq_err), .timeout_err(timeout_err), .busy(busy)
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [32:0] sb [$];
  int          xin_cnt = 0, clr_cnt = 0, occ = 0, max_occ = 0;
  logic        dp_mute = 1'b0, inj = 1'b0, dp_real = 1'b0;
  logic [15:0] dp_x;
  int          dp_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_y(input logic [15:0] x);
    return 16'(x * 16'd3 + 16'd1);
  endfunction

  function automatic logic [15:0] exp_c(input logic [15:0] x);
    return x ^ 16'h5A5A;
  endfunction

  // Datapath model: result LAT cycles after each issue strobe, unless muted.
  initial begin
    lstm_valid = 1'b0; lstm_y_out = '0; lstm_c_out = '0; dp_cnt = 0; dp_x = '0;
    forever begin
      @(posedge clk); #1;
      lstm_valid = 1'b0;
      dp_real    = 1'b0;
      if (!rst_n) begin
        dp_cnt = 0;
      end else if (inj) begin
        lstm_valid = 1'b1; lstm_y_out = 16'hDEAD; lstm_c_out = 16'hBEEF; inj = 1'b0;
      end else if (lstm_x_in_valid && !dp_mute) begin
        dp_cnt = LAT; dp_x = lstm_x_in;
      end else if (dp_cnt != 0) begin
        dp_cnt--;
        if (dp_cnt == 0) begin
          lstm_valid = 1'b1; dp_real = 1'b1;
          lstm_y_out = exp_y(dp_x); lstm_c_out = exp_c(dp_x);
        end
      end
    end
  end

  // Output monitor: scoreboard pops, occupancy model, strobe counters.
  always @(negedge clk) begin : mon
    logic [32:0] e;
    #2;
    if (!rst_n) begin
      occ = 0;
    end else begin
      check("m_valid_occ", 32'(m_valid), 32'(occ != 0));
      if (lstm_x_in_valid) xin_cnt++;
      if (lstm_c_in_valid != '0) begin
        clr_cnt++;
        check("clr_all", 32'(lstm_c_in_valid & lstm_h_in_valid), 32'hF);
        check("clr_data", 32'(|{lstm_c_in, lstm_h_in}), 32'd0);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("m_y", 32'(m_y), 32'(e[32:17]));
          check("m_c", 32'(m_c), 32'(e[16:1]));
          check("m_last", 32'(m_last), 32'(e[0]));
        end
        occ--;
      end
      if (lstm_valid && dp_real) occ++;
      if (occ > max_occ) max_occ = occ;
    end
  end

  task automatic send(input logic [15:0] d, input logic first, input logic last, input int exp_lat);
    int start;
    bit ok;
    s_data = d; s_first = first; s_last = last; s_valid = 1'b1;
    start = cyc; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
    if (!ok) begin
      check("send_stuck", 32'd0, 32'd1);
      return;
    end
    if (!dp_mute) sb.push_back({exp_y(d), exp_c(d), last});
    check("x_in_valid", 32'(lstm_x_in_valid), 32'd1);
    check("x_in", 32'(lstm_x_in), 32'(d));
    if (exp_lat >= 0) check("hs_latency", 32'(cyc - start - 1), 32'(exp_lat));
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk); #1;
      done = !busy && (sb.size() == 0) && !m_valid;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, c0;
    bit done;
    rst_n = 1'b0; s_data = '0; s_first = 1'b0; s_last = 1'b0; s_valid = 1'b0;
    lstm_ready = 1'b1; m_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_x_valid", 32'(lstm_x_in_valid), 32'd0);
    check("rst_clr", 32'(lstm_c_in_valid | lstm_h_in_valid), 32'd0);
    check("rst_seq_count", 32'(seq_count), 32'd0);
    check("rst_flags", 32'({seq_err, timeout_err}), 32'd0);
    check("rst_m_y", 32'(m_y), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three-sample sequence
    base = xin_cnt; c0 = clr_cnt;
    send(16'h0011, 1'b1, 1'b0, 2);
    send(16'h0022, 1'b0, 1'b0, -1);
    send(16'h0033, 1'b0, 1'b1, -1);
    wait_idle("idle_seq3");
    check("seq_count_3", 32'(seq_count), 32'd3);
    check("clr_pulses_1", 32'(clr_cnt - c0), 32'd1);
    check("xin_count_3", 32'(xin_cnt - base), 32'd3);

    // Non-first sample from IDLE: no clear, one-cycle latency
    c0 = clr_cnt;
    send(16'h0044, 1'b0, 1'b1, 1);
    wait_idle("idle_nofirst");
    check("seq_count_4", 32'(seq_count), 32'd4);
    check("no_clr", 32'(clr_cnt - c0), 32'd0);

    // Backpressure: 6 samples with consumer stalled
    m_ready = 1'b0; base = xin_cnt; max_occ = 0;
    fork
      for (int i = 0; i < 6; i++) send(16'h0100 + 16'(i), 1'(i == 0), 1'(i == 5), -1);
      begin
        repeat (60) @(posedge clk); #1;
        check("bp_issued_4", 32'(xin_cnt - base), 32'd4);
        check("bp_occ_4", 32'(occ), 32'd4);
        check("bp_s_ready", 32'(s_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        m_ready = 1'b1;
      end
    join
    wait_idle("idle_bp");
    check("bp_issued_6", 32'(xin_cnt - base), 32'd6);
    check("bp_max_occ", 32'(max_occ), 32'd4);

    // s_first arriving mid-sequence
    check("seq_err_pre", 32'(seq_err), 32'd0);
    send(16'h0200, 1'b1, 1'b0, -1);
    send(16'h0201, 1'b0, 1'b0, -1);
    c0 = clr_cnt;
    send(16'h0202, 1'b1, 1'b0, -1);
    check("seq_err_set", 32'(seq_err), 32'd1);
    check("seq_restart", 32'(seq_count), 32'd1);
    check("seq_err_clr", 32'(clr_cnt - c0), 32'd1);
    send(16'h0203, 1'b0, 1'b1, -1);
    wait_idle("idle_seqerr");
    check("seq_count_2", 32'(seq_count), 32'd2);

    // Datapath never answers
    dp_mute = 1'b1;
    send(16'h0300, 1'b1, 1'b1, 2);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("to_not_yet", 32'(timeout_err), 32'd0);
    check("to_busy_pre", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("to_set", 32'(timeout_err), 32'd1);
    check("to_busy_post", 32'(busy), 32'd0);
    check("to_no_push", 32'(m_valid), 32'd0);
    check("seq_err_sticky", 32'(seq_err), 32'd1);
    dp_mute = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Random consumer stalls across pointer wrap
    done = 1'b0; max_occ = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) send(16'h0400 + 16'(i * 37), 1'(i == 0), 1'(i == 11), -1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
      end
    join
    wait_idle("idle_rand");
    check("rand_max_occ", 32'(max_occ <= 4), 32'd1);
    check("timeout_sticky", 32'(timeout_err), 32'd1);

    // Reset in WAIT with two results buffered
    m_ready = 1'b0;
    send(16'h0500, 1'b1, 1'b0, -1);
    send(16'h0501, 1'b0, 1'b0, -1);
    send(16'h0502, 1'b0, 1'b0, -1);
    repeat (2) @(posedge clk); #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_occ", 32'(occ), 32'd2);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    sb.delete();
    #1;
    check("post_rst_m_valid", 32'(m_valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_flags", 32'({seq_err, timeout_err}), 32'd0);
    check("post_rst_seq_count", 32'(seq_count), 32'd0);
    check("post_rst_x_in", 32'(lstm_x_in), 32'd0);
    @(posedge clk); #1;
    inj = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("stray_no_result", 32'(m_valid), 32'd0);
    check("stray_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
